// File: rtl/apb_stepper_multi.sv
// APB3 slave driving NUM_CH step/dir stepper channels with remaining-count readback,
// abort, sticky done with maskable interrupt and a synchronous multi-channel start.
module apb_stepper_multi #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned PER_W     = 16,
  parameter int unsigned PULSE_CYC = 50
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] dir,
  output logic              irq
);

  typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

  localparam logic [PER_W-1:0] PulseLast = PER_W'(PULSE_CYC - 1);
  localparam logic [PER_W-1:0] MinPeriod = PER_W'(2 * PULSE_CYC);

  logic       acc_en;
  logic       wr_en;
  logic [2:0] ch_idx;
  logic [1:0] reg_off;
  logic       ch_ok;
  logic       irq_en_hit;
  logic       sync_hit;
  logic       mapped;
  logic       unused_bits;

  assign acc_en     = PSEL & PENABLE;
  assign wr_en      = acc_en & PWRITE;
  assign ch_idx     = PADDR[6:4];
  assign reg_off    = PADDR[3:2];
  assign ch_ok      = ~PADDR[7] && (32'(ch_idx) < NUM_CH);
  assign irq_en_hit = (PADDR[7:2] == 6'h20);
  assign sync_hit   = (PADDR[7:2] == 6'h21);
  assign mapped     = ch_ok | irq_en_hit | sync_hit;
  assign PSLVERR    = acc_en & ~mapped;
  assign PREADY     = 1'b1;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  logic [NUM_CH-1:0][CNT_W-1:0] rem_w;
  logic [NUM_CH-1:0][PER_W-1:0] period_w;
  logic [NUM_CH-1:0]            busy_w;
  logic [NUM_CH-1:0]            done_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] eff_q, eff_d;
    logic [PER_W-1:0] phase_q, phase_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             hit, ctrl_wr, steps_wr, period_wr, status_wr;
    logic             start_req, abort_req, idle, enter_hi;

    assign hit       = wr_en && ~PADDR[7] && (ch_idx == 3'(c));
    assign ctrl_wr   = hit && (reg_off == 2'd0);
    assign steps_wr  = hit && (reg_off == 2'd1);
    assign period_wr = hit && (reg_off == 2'd2);
    assign status_wr = hit && (reg_off == 2'd3);
    assign abort_req = ctrl_wr && PWDATA[2];
    assign start_req = (ctrl_wr && PWDATA[0]) || (wr_en && sync_hit && PWDATA[c]);
    assign idle      = (state_q == StIdle);

    always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      period_d = period_q;
      eff_d    = eff_q;
      phase_d  = phase_q;
      step_d   = step_q;
      dir_d    = dir_q;
      done_d   = done_q;
      enter_hi = 1'b0;

      if (period_wr) period_d = PWDATA[PER_W-1:0];
      if (status_wr && PWDATA[1]) done_d = 1'b0;
      if (idle && steps_wr) rem_d = PWDATA[CNT_W-1:0];
      if (idle && ctrl_wr && !abort_req) dir_d = PWDATA[1];

      // Abort beats any start in the same write; done and remaining count are kept.
      if (abort_req) begin
        state_d = StIdle;
        step_d  = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_req) begin
              if (rem_q != '0) enter_hi = 1'b1;
              else             done_d   = 1'b1;
            end
          end
          StHi: begin
            phase_d = phase_q + PER_W'(1);
            if (phase_q == PulseLast) begin
              state_d = StLo;
              step_d  = 1'b0;
            end
          end
          StLo: begin
            if (phase_q == eff_q - PER_W'(1)) begin
              if (rem_q != '0) begin
                enter_hi = 1'b1;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
            end else begin
              phase_d = phase_q + PER_W'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end

      // Period is sampled at each HI entry so a mid-move write applies to the next step.
      if (enter_hi) begin
        state_d = StHi;
        step_d  = 1'b1;
        rem_d   = rem_q - CNT_W'(1);
        phase_d = '0;
        eff_d   = (period_q < MinPeriod) ? MinPeriod : period_q;
      end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        state_q  <= StIdle;
        rem_q    <= '0;
        period_q <= '0;
        eff_q    <= '0;
        phase_q  <= '0;
        step_q   <= 1'b0;
        dir_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        rem_q    <= rem_d;
        period_q <= period_d;
        eff_q    <= eff_d;
        phase_q  <= phase_d;
        step_q   <= step_d;
        dir_q    <= dir_d;
        done_q   <= done_d;
      end
    end

    assign step[c]     = step_q;
    assign dir[c]      = dir_q;
    assign rem_w[c]    = rem_q;
    assign period_w[c] = period_q;
    assign busy_w[c]   = ~idle;
    assign done_w[c]   = done_q;
  end

  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_en && irq_en_hit) irq_en_d = PWDATA[NUM_CH-1:0];
    irq_d = |(done_w & irq_en_q);
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    PRDATA = '0;
    if (irq_en_hit) PRDATA = 32'(irq_en_q);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ok && (int'(ch_idx) == c)) begin
        case (reg_off)
          2'd1:    PRDATA = 32'(rem_w[c]);
          2'd2:    PRDATA = 32'(period_w[c]);
          2'd3:    PRDATA = {30'd0, done_w[c], busy_w[c]};
          default: PRDATA = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_stepper_multi.sv
// Directed bench for apb_stepper_multi with NUM_CH=2 and PULSE_CYC=2; cycle offsets are
// relative to T, the access cycle of the START write.
module tb_apb_stepper_multi;

  logic        PCLK = 1'b0;
  logic        PRESERN, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  step, dir;
  logic        irq;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd;
  logic        err;

  always #5 PCLK = ~PCLK;

  apb_stepper_multi #(
    .NUM_CH(2), .CNT_W(24), .PER_W(16), .PULSE_CYC(2)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .step(step), .dir(dir), .irq(irq)
  );

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // Called at a negedge: setup this cycle, access next cycle, returns one cycle later.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK); PENABLE = 1'b1;
    #1 d = PRDATA; e = PSLVERR;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    checks++; if (step !== 2'b00) begin errors++; $display("FAIL rst_step got=%b exp=00", step); end
    checks++; if (dir !== 2'b00) begin errors++; $display("FAIL rst_dir got=%b exp=00", dir); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
    apb_read(8'h04, rd, err);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_steps got=%0h exp=0", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_slverr got=%b exp=0", err); end
    apb_read(8'h08, rd, err);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_period got=%0h exp=0", rd); end
    apb_read(8'h1C, rd, err);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_status1 got=%0h exp=0", rd); end
    apb_read(8'h80, rd, err);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_irqen got=%0h exp=0", rd); end
  endtask

  task automatic test_single_move();
    apb_write(8'h04, 32'd3);
    apb_write(8'h08, 32'd10);
    apb_write(8'h00, 32'h3);                              // now T+1
    checks++; if (step[0] !== 1'b1) begin errors++; $display("FAIL mv_step_t1 got=%b exp=1", step[0]); end
    checks++; if (dir[0] !== 1'b1) begin errors++; $display("FAIL mv_dir got=%b exp=1", dir[0]); end
    apb_read(8'h04, rd, err);                             // sampled T+2
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL mv_rem2 got=%0d exp=2", rd); end
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL mv_step_t3 got=%b exp=0", step[0]); end
    idle_cycles(8);                                       // T+11
    checks++; if (step[0] !== 1'b1) begin errors++; $display("FAIL mv_step_t11 got=%b exp=1", step[0]); end
    apb_read(8'h04, rd, err);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL mv_rem1 got=%0d exp=1", rd); end
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL mv_step_t13 got=%b exp=0", step[0]); end
    idle_cycles(8);                                       // T+21
    checks++; if (step[0] !== 1'b1) begin errors++; $display("FAIL mv_step_t21 got=%b exp=1", step[0]); end
    apb_read(8'h04, rd, err);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL mv_rem0 got=%0d exp=0", rd); end
    apb_read(8'h0C, rd, err);                             // sampled T+24
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mv_busy got=%0h exp=1", rd); end
    idle_cycles(3);                                       // T+28
    apb_read(8'h0C, rd, err);                             // sampled T+29
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mv_busy_t29 got=%0h exp=1", rd); end
    apb_read(8'h0C, rd, err);                             // sampled T+31
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL mv_done_t31 got=%0h exp=2", rd); end
    apb_write(8'h0C, 32'h2);
    apb_read(8'h0C, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mv_w1c got=%0h exp=0", rd); end
  endtask

  task automatic test_min_period_zero_steps();
    apb_write(8'h08, 32'd1);
    apb_write(8'h04, 32'd2);
    apb_write(8'h00, 32'h1);                              // T+1, effective period 4
    checks++; if (dir[0] !== 1'b0) begin errors++; $display("FAIL mp_dir got=%b exp=0", dir[0]); end
    idle_cycles(2);                                       // T+3
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL mp_step_t3 got=%b exp=0", step[0]); end
    idle_cycles(1);                                       // T+4
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL mp_step_t4 got=%b exp=0", step[0]); end
    idle_cycles(1);                                       // T+5
    checks++; if (step[0] !== 1'b1) begin errors++; $display("FAIL mp_step_t5 got=%b exp=1", step[0]); end
    idle_cycles(1);
    apb_read(8'h0C, rd, err);                             // sampled T+7
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mp_busy_t7 got=%0h exp=1", rd); end
    apb_read(8'h0C, rd, err);                             // sampled T+9
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL mp_done_t9 got=%0h exp=2", rd); end
    apb_write(8'h0C, 32'h2);
    apb_write(8'h04, 32'd0);
    apb_write(8'h00, 32'h1);                              // START with zero steps
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL zs_step got=%b exp=0", step[0]); end
    apb_read(8'h0C, rd, err);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL zs_done got=%0h exp=2", rd); end
    idle_cycles(3);
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL zs_nopulse got=%b exp=0", step[0]); end
    apb_write(8'h0C, 32'h2);
  endtask

  task automatic test_sync_start();
    apb_write(8'h04, 32'd5);
    apb_write(8'h08, 32'd10);
    apb_write(8'h14, 32'd7);
    apb_write(8'h18, 32'd10);
    apb_write(8'h10, 32'h2);                              // latch DIR=1 on ch1, no start
    apb_write(8'h84, 32'h3);                              // T+1
    checks++; if (step !== 2'b11) begin errors++; $display("FAIL sy_step got=%b exp=11", step); end
    checks++; if (dir !== 2'b10) begin errors++; $display("FAIL sy_dir got=%b exp=10", dir); end
    idle_cycles(49);                                      // T+50
    apb_read(8'h0C, rd, err);                             // sampled T+51
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL sy_done0 got=%0h exp=2", rd); end
    apb_read(8'h1C, rd, err);                             // sampled T+53
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL sy_busy1 got=%0h exp=1", rd); end
    idle_cycles(15);                                      // T+69
    apb_read(8'h1C, rd, err);                             // sampled T+70
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL sy_busy1_t70 got=%0h exp=1", rd); end
    apb_read(8'h1C, rd, err);                             // sampled T+72
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL sy_done1 got=%0h exp=2", rd); end
    apb_write(8'h0C, 32'h2);
    apb_write(8'h1C, 32'h2);
  endtask

  task automatic test_abort();
    apb_write(8'h04, 32'd10);
    apb_write(8'h08, 32'd10);
    apb_write(8'h00, 32'h1);                              // T+1
    idle_cycles(10);                                      // T+11, second HI
    checks++; if (step[0] !== 1'b1) begin errors++; $display("FAIL ab_hi2 got=%b exp=1", step[0]); end
    apb_write(8'h00, 32'h4);
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL ab_step got=%b exp=0", step[0]); end
    apb_read(8'h04, rd, err);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL ab_rem got=%0d exp=8", rd); end
    apb_read(8'h0C, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ab_status got=%0h exp=0", rd); end
    idle_cycles(10);
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL ab_stays got=%b exp=0", step[0]); end
    apb_write(8'h00, 32'h5);                              // ABORT with START
    checks++; if (step[0] !== 1'b0) begin errors++; $display("FAIL ab_wins got=%b exp=0", step[0]); end
    apb_read(8'h04, rd, err);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL ab_wins_rem got=%0d exp=8", rd); end
  endtask

  task automatic test_busy_ignore();
    apb_write(8'h04, 32'd2);
    apb_write(8'h08, 32'd4);
    apb_write(8'h00, 32'h1);                              // T+1
    apb_write(8'h04, 32'd9);                              // ignored while busy
    apb_write(8'h00, 32'h3);                              // START/DIR ignored, now T+5
    checks++; if (step[0] !== 1'b1) begin errors++; $display("FAIL bi_step got=%b exp=1", step[0]); end
    checks++; if (dir[0] !== 1'b0) begin errors++; $display("FAIL bi_dir got=%b exp=0", dir[0]); end
    apb_read(8'h04, rd, err);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL bi_rem got=%0d exp=0", rd); end
    idle_cycles(1);
    apb_read(8'h0C, rd, err);                             // sampled T+9
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL bi_done got=%0h exp=2", rd); end
    apb_write(8'h0C, 32'h2);
  endtask

  task automatic test_irq();
    apb_write(8'h80, 32'h1);
    apb_read(8'h80, rd, err);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL iq_en got=%0h exp=1", rd); end
    apb_write(8'h04, 32'd1);
    apb_write(8'h08, 32'd4);
    apb_write(8'h00, 32'h1);                              // T+1
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL iq_t1 got=%b exp=0", irq); end
    idle_cycles(4);                                       // T+5, done just set
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL iq_t5 got=%b exp=0", irq); end
    idle_cycles(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL iq_t6 got=%b exp=1", irq); end
    apb_write(8'h0C, 32'h2);                              // T+8
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL iq_t8 got=%b exp=1", irq); end
    idle_cycles(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL iq_fall got=%b exp=0", irq); end
    // W1C committing in the completion cycle must lose to the set
    apb_write(8'h04, 32'd1);
    apb_write(8'h00, 32'h1);                              // T+1
    idle_cycles(2);
    apb_write(8'h0C, 32'h2);                              // commits in T+4
    apb_read(8'h0C, rd, err);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL iq_setwins got=%0h exp=2", rd); end
    apb_write(8'h80, 32'h0);
    idle_cycles(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL iq_masked got=%b exp=0", irq); end
    apb_write(8'h0C, 32'h2);
  endtask

  task automatic test_unmapped();
    apb_read(8'h40, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL um_err40 got=%b exp=1", err); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL um_data40 got=%0h exp=0", rd); end
    apb_read(8'h90, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL um_err90 got=%b exp=1", err); end
    apb_write(8'h48, 32'd77);
    apb_read(8'h08, rd, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL um_err08 got=%b exp=0", err); end
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL um_period got=%0d exp=4", rd); end
  endtask

  task automatic test_async_reset();
    apb_write(8'h04, 32'd3);
    apb_write(8'h08, 32'd10);
    apb_write(8'h00, 32'h3);                              // T+1, mid-HI
    checks++; if (step[0] !== 1'b1) begin errors++; $display("FAIL ar_hi got=%b exp=1", step[0]); end
    #2 PRESERN = 1'b0;
    #1;
    checks++; if (step !== 2'b00) begin errors++; $display("FAIL ar_step got=%b exp=00", step); end
    checks++; if (dir !== 2'b00) begin errors++; $display("FAIL ar_dir got=%b exp=00", dir); end
    @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    apb_read(8'h04, rd, err);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL ar_steps got=%0d exp=0", rd); end
    apb_read(8'h0C, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ar_status got=%0h exp=0", rd); end
    idle_cycles(12);
    checks++; if (step !== 2'b00) begin errors++; $display("FAIL ar_norestart got=%b exp=00", step); end
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_min_period_zero_steps();
    test_sync_start();
    test_abort();
    test_busy_ignore();
    test_irq();
    test_unmapped();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_stepper_multi.md
# apb_stepper_multi

Parametrised APB3 slave driving `NUM_CH` step/dir stepper channels for the plotter. It sits behind a CoreAPB3 slot and is clocked from the MSS fabric clock. Each channel runs a programmed number of steps at a programmed period and direction. Over the two-channel controller it adds remaining-count readback, abort, a sticky done flag with a maskable interrupt, and a synchronous multi-channel start so that both axes begin a line on the same clock.

## Interface
Parameters:
- `NUM_CH`, default 2: number of channels, 1..4.
- `CNT_W`, default 24: step-count width.
- `PER_W`, default 16: step-period width, in PCLK cycles.
- `PULSE_CYC`, default 50: step high time in PCLK cycles, ≥1.

Ports:
- `PCLK` in 1: the single clock.
- `PRESERN` in 1: reset, asynchronous, active-low.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB3 control.
- `PADDR` in 8: byte address; bits [1:0] ignored.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data, combinational from `PADDR`.
- `PREADY` out 1: constant 1; no wait states.
- `PSLVERR` out 1: high during the access phase of an unmapped access.
- `step` out NUM_CH: step pulses, registered.
- `dir` out NUM_CH: direction, registered.
- `irq` out 1: OR over channels of (done & irq_en).

## Operation
Register map. Channel c occupies base c*0x10.
- +0x0 CTRL, write-only, reads 0. Bit0 START, bit1 DIR, bit2 ABORT.
- +0x4 STEPS. Write loads the target count. Read returns the remaining count.
- +0x8 PERIOD, R/W. Effective period = max(PERIOD, 2*PULSE_CYC).
- +0xC STATUS. Bit0 busy (RO), bit1 done (sticky, write-1-to-clear).
- 0x80 IRQ_EN, R/W, [NUM_CH-1:0].
- 0x84 SYNC_START, write-only, mask [NUM_CH-1:0]. Each set bit acts as START for that channel using that channel's latched DIR.
- Any other address, or a channel index ≥ NUM_CH, sets `PSLVERR`=1. Writes to such addresses have no effect; reads return 0.

A write commits on the cycle where PSEL & PENABLE & PWRITE are all high.

Per-channel FSM states IDLE, HI, LO:
- IDLE -> HI on START when STEPS≠0. `dir` is loaded from CTRL.DIR, busy=1, and the phase counter is cleared.
- START with STEPS=0: the channel stays IDLE, done=1 the next cycle, and no pulse is issued.
- HI: `step`=1 for PULSE_CYC cycles. The remaining count decrements on entry to HI.
- HI -> LO after PULSE_CYC cycles. LO lasts (effective period − PULSE_CYC) cycles.
- LO -> HI if remaining ≠ 0. LO -> IDLE if remaining = 0; on that cycle busy=0 and done=1.
- ABORT in any state: IDLE the next cycle, `step`=0, done unchanged, remaining count preserved.
- ABORT and START in the same CTRL write: ABORT wins.

While busy:
- START, SYNC_START, DIR and STEPS writes are ignored.
- A PERIOD write is accepted and applies from the next HI entry.

Arithmetic:
- The remaining counter is CNT_W bits and never wraps below 0.
- The phase counter is PER_W bits, unsigned.
- PWDATA bits above the field width are dropped; reads zero-extend.

## Timing
Reset values: `step`=0, `dir`=0, `irq`=0, STEPS=0, PERIOD=0, busy=0, done=0, IRQ_EN=0, `PSLVERR`=0.

Latency:
- START write commits in cycle T. `step` rises at T+1 (`dir` valid at T+1).
- Step rising edges occur every effective period.
- busy falls and done rises at T+1 + N*effective_period for N steps.
- `irq` follows done & irq_en one cycle later (registered).
- SYNC_START: all selected channels' `step` rise in the same cycle.
- A done W1C write in the same cycle as a completion leaves done=1: set wins.

Reset asserted mid-move: all outputs go to their reset values immediately (asynchronously). The channel restarts only on a new START after release.

## Test plan
PULSE_CYC=2 unless noted.
- Ch0 STEPS=3, PERIOD=10, START DIR=1 -> `step[0]` rises at T+1, T+11 and T+21, each high for 2 cycles. `dir[0]`=1. done at T+31. STEPS reads 2, 1, 0 during the move.
- PERIOD=1 -> effective period is 4. STEPS=0 with START -> no pulse, and done=1 at T+1.
- Ch0 STEPS=5 and ch1 STEPS=7, SYNC_START=0b11 -> coincident first edges. Ch0 done 20 cycles before ch1 at PERIOD=10.
- ABORT at the 2nd HI of a 10-step move -> `step`=0 the next cycle. STEPS reads 8, busy=0, done=0.
- IRQ_EN=1 and move completes -> `irq`=1. Writing STATUS=0x2 clears done, and `irq` falls the following cycle.
- Read of 0x40 with NUM_CH=2 -> `PSLVERR`=1 and PRDATA=0. Async `PRESERN` pulse mid-HI -> `step`=0 with no clock edge required.
